// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one word-aligned request to instruction memory, captures the
// response into a hold register, and presents it to decode with a
// valid/ready handshake. Redirects from downstream replace the PC. A
// redirect that arrives while a request is in flight marks that response
// for discard (flush), because the memory request cannot be withdrawn.
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   imem_req/imem_addr         fetch request and word address (addr = pc)
//   imem_valid/imem_rdata      one-cycle memory response strobe and data
//   inst_valid/inst_ready      decode handshake
//   inst/opcode/func/inst_pc   held instruction, its decode fields, its address
//   redirect_valid/_target     PC redirect (target bits [1:0] forced to 0)
//   halt                       level; suppresses issue of new fetches
//   fetch_count                number of instructions accepted by decode
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_b,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [5:0]            opcode,
  output logic [5:0]            func,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  output logic [31:0]           fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] tgt_aligned;

  logic                  req_nxt;
  logic                  valid_nxt;
  logic                  capture;
  logic                  accept;

  // Word-align the redirect target by masking the low two bits.
  assign tgt_aligned = redirect_target & ~ADDR_WIDTH'(3);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!halt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response is only kept when no redirect is pending or coincident.
        if (imem_valid) begin
          if (redirect_valid || flush) state_nxt = halt ? S_IDLE : S_WAIT;
          else                         state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) state_nxt = halt ? S_IDLE : S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/strobe logic; handshake outputs are registered from the next state.
  always_comb begin
    req_nxt   = 1'b0;
    valid_nxt = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    req_nxt   = (state_nxt == S_WAIT);
    valid_nxt = (state_nxt == S_HOLD);
    capture   = (state == S_WAIT) && imem_valid && !redirect_valid && !flush;
    // A redirect in HOLD kills the held instruction even if decode is ready.
    accept    = (state == S_HOLD) && inst_ready && !redirect_valid;
  end

  // Registered outputs and PC datapath.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
      pc          <= RESET_PC;
      pc_next     <= RESET_PC;
      flush       <= 1'b0;
    end else begin
      imem_req   <= req_nxt;
      inst_valid <= valid_nxt;

      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end

      if (accept) fetch_count <= fetch_count + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (redirect_valid) pc <= tgt_aligned;
        end
        S_WAIT: begin
          if (imem_valid) begin
            flush <= 1'b0;
            if (redirect_valid) pc <= tgt_aligned;
            else if (flush)     pc <= pc_next;
            else                pc <= pc + ADDR_WIDTH'(4);
          end else if (redirect_valid) begin
            // Request stays on the bus; remember where to go once it returns.
            pc_next <= tgt_aligned;
            flush   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) pc <= tgt_aligned;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = inst[31:26];
  assign func      = inst[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt = 1'b1;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .opcode          (opcode),
    .func            (func),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic        ready;
    logic        mvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ival;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  localparam logic [31:0] I0 = 32'h2008_0005;
  localparam logic [31:0] I1 = 32'h8C22_0004;
  localparam logic [31:0] I2 = 32'h0C00_0040;
  localparam logic [31:0] I3 = 32'h0085_1020;
  localparam logic [31:0] I4 = 32'hAC00_0000;

  function automatic vec_t mk(input logic h, input logic r, input logic mv,
                              input logic [31:0] rd, input logic rv,
                              input logic [31:0] tg, input logic eq,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ec);
    vec_t v;
    v.halt = h;  v.ready = r;  v.mvalid = mv; v.rdata = rd;
    v.redir = rv; v.tgt = tg;  v.e_req = eq;  v.e_addr = ea;
    v.e_ival = ev; v.e_inst = ei; v.e_ipc = ep; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eq, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [31:0] ec);
    logic [31:0] ei_l;
    ei_l = ei;
    check({tag, " imem_req"},    32'(imem_req),    32'(eq));
    check({tag, " imem_addr"},   imem_addr,        ea);
    check({tag, " inst_valid"},  32'(inst_valid),  32'(ev));
    check({tag, " inst"},        inst,             ei_l);
    check({tag, " inst_pc"},     inst_pc,          ep);
    check({tag, " fetch_count"}, fetch_count,      ec);
    check({tag, " opcode"},      32'(opcode),      32'(ei_l[31:26]));
    check({tag, " func"},        32'(func),        32'(ei_l[5:0]));
  endtask

  initial begin
    //            halt rdy mv rdata          rv tgt            | req addr          iv inst ipc           cnt
    vt[0]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, 32'h0, 32'h0,         0);
    vt[1]  = mk(0, 0, 1, I0,             0, 32'h0,          0, 32'h4,         1, I0, 32'h0,            0);
    vt[2]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h4,         0, I0, 32'h0,            1);
    vt[3]  = mk(0, 0, 1, I1,             0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[4]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[5]  = mk(0, 0, 1, 32'hDEAD_BEEF,  0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[6]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[7]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[8]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h8,         1, I1, 32'h4,            1);
    vt[9]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h8,         0, I1, 32'h4,            2);
    vt[10] = mk(1, 0, 0, 32'h0,          1, 32'h203,        0, 32'h200,       0, I1, 32'h4,            2);
    vt[11] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h200,       0, I1, 32'h4,            2);
    vt[12] = mk(0, 0, 0, 32'h0,          1, 32'h103,        1, 32'h200,       0, I1, 32'h4,            2);
    vt[13] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h200,       0, I1, 32'h4,            2);
    vt[14] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h200,       0, I1, 32'h4,            2);
    vt[15] = mk(0, 0, 1, 32'h1111_1111,  0, 32'h0,          1, 32'h100,       0, I1, 32'h4,            2);
    vt[16] = mk(0, 0, 0, 32'h0,          1, 32'h203,        1, 32'h100,       0, I1, 32'h4,            2);
    vt[17] = mk(0, 0, 0, 32'h0,          1, 32'h307,        1, 32'h100,       0, I1, 32'h4,            2);
    vt[18] = mk(0, 0, 1, 32'h2222_2222,  0, 32'h0,          1, 32'h304,       0, I1, 32'h4,            2);
    vt[19] = mk(0, 0, 1, I2,             0, 32'h0,          0, 32'h308,       1, I2, 32'h304,          2);
    vt[20] = mk(0, 1, 0, 32'h0,          1, 32'h400,        1, 32'h400,       0, I2, 32'h304,          2);
    vt[21] = mk(0, 0, 1, 32'h3333_3333,  1, 32'h500,        1, 32'h500,       0, I2, 32'h304,          2);
    vt[22] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h500,       0, I2, 32'h304,          2);
    vt[23] = mk(1, 0, 1, I3,             0, 32'h0,          0, 32'h504,       1, I3, 32'h500,          2);
    vt[24] = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h504,       0, I3, 32'h500,          3);
    vt[25] = mk(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFE,  0, 32'hFFFF_FFFC, 0, I3, 32'h500,          3);
    vt[26] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC, 0, I3, 32'h500,          3);
    vt[27] = mk(0, 0, 1, I4,             0, 32'h0,          0, 32'h0,         1, I4, 32'hFFFF_FFFC,    3);
    vt[28] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, I4, 32'hFFFF_FFFC,    4);
    vt[29] = mk(0, 0, 0, 32'h0,          1, 32'h10,         1, 32'h0,         0, I4, 32'hFFFF_FFFC,    4);
    vt[30] = mk(1, 0, 1, 32'h4444_4444,  0, 32'h0,          0, 32'h10,        0, I4, 32'hFFFF_FFFC,    4);

    // Asynchronous reset before any clock edge.
    #1 rst_b = 1'b0;
    #1 check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_b           = 1'b1;
      halt            = vt[i].halt;
      inst_ready      = vt[i].ready;
      imem_valid      = vt[i].mvalid;
      imem_rdata      = vt[i].rdata;
      redirect_valid  = vt[i].redir;
      redirect_target = vt[i].tgt;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_ival,
                vt[i].e_inst, vt[i].e_ipc, vt[i].e_cnt);
    end

    // Reset pulsed mid-WAIT: request drops immediately, stale response ignored.
    @(negedge clk);
    halt = 1'b0; inst_ready = 1'b0; imem_valid = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    check_all("rw_wait", 1'b1, 32'h10, 1'b0, I4, 32'hFFFF_FFFC, 32'd4);
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    check_all("rw_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_b = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    check_all("rw_rel", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    imem_valid = 1'b0;
    @(posedge clk); #1;
    check_all("rw_hold", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = I0;
    @(posedge clk); #1;
    check_all("rw_resp", 1'b0, 32'h4, 1'b1, I0, 32'h0, 32'h0);
    @(negedge clk);
    imem_valid = 1'b0; inst_ready = 1'b1;
    @(posedge clk); #1;
    check_all("rw_acc", 1'b1, 32'h4, 1'b0, I0, 32'h0, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first instruction address after reset.
REQ-002 Parameter ADDR_WIDTH, default 32, meaning width of all address and PC signals.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_b  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction memory request, held until imem_valid.
REQ-006 imem_addr  output  ADDR_WIDTH  word-aligned fetch address, stable while imem_req=1.
REQ-007 imem_valid  input  1  memory response strobe, one cycle per request.
REQ-008 imem_rdata  input  32  instruction word, sampled when imem_valid=1.
REQ-009 inst_valid  output  1  decode-side instruction valid.
REQ-010 inst_ready  input  1  decode accepts the instruction when inst_valid and inst_ready are both 1.
REQ-011 inst  output  32  held instruction word.
REQ-012 opcode  output  6  inst[31:26], feeding the control decoder.
REQ-013 func  output  6  inst[5:0], feeding the control decoder.
REQ-014 inst_pc  output  ADDR_WIDTH  address of the held instruction.
REQ-015 redirect_valid  input  1  taken branch, j, jal or jr resolved downstream.
REQ-016 redirect_target  input  ADDR_WIDTH  new PC; bits [1:0] are ignored and forced to 0.
REQ-017 halt  input  1  level; blocks issue of new fetches.
REQ-018 fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-019 State machine states: IDLE, WAIT, HOLD.
REQ-020 IDLE: imem_req=0 and inst_valid=0.
  - If halt=0, the unit enters WAIT next cycle with imem_addr=pc.
REQ-021 WAIT: imem_req=1 with imem_addr=pc.
  - On imem_valid with no pending flush: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4; next state HOLD.
REQ-022 HOLD: inst_valid=1; inst, inst_pc, opcode and func stay stable until accepted.
REQ-023 On acceptance in HOLD, fetch_count increments by 1.
  - Next state is WAIT if halt=0, otherwise IDLE.
  - Back-to-back throughput is therefore one instruction per 2 cycles with zero-latency memory.
REQ-024 Minimum latency from entering WAIT to inst_valid=1 is one cycle after imem_valid.
REQ-025 A redirect in IDLE sets pc<=target; the held instruction is unaffected.
REQ-026 A redirect in HOLD sets pc<=target and drops inst_valid next cycle.
  - The instruction is not counted, even if inst_ready=1 in the same cycle.
  - Next state is WAIT if halt=0, otherwise IDLE.
REQ-027 A redirect in WAIT without imem_valid sets pc_next<=target and sets the flush flag.
  - imem_req and imem_addr stay unchanged until imem_valid arrives.
REQ-028 imem_valid with the flush flag set: the response is discarded and the flag clears.
  - pc<=pc_next; next state WAIT, or IDLE if halt=1.
REQ-029 A redirect coincident with imem_valid in WAIT: the response is discarded and pc<=target.
REQ-030 A later redirect while the flush flag is set overwrites pc_next; the last redirect wins.
REQ-031 halt never aborts an outstanding request; it only prevents the next one from issuing.
REQ-032 PC arithmetic is modulo 2^ADDR_WIDTH.
  - 32'hFFFF_FFFC + 4 wraps to 0.
REQ-033 fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-034 imem_valid outside WAIT is ignored.

Reset
REQ-035 rst_b=0 asynchronously forces the following values, independent of clk:
  - state IDLE, pc=RESET_PC, flush flag clear, imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_count=0.
REQ-036 Reset mid-transaction abandons the request.
  - The next fetch after release is issued from RESET_PC.
REQ-037 The first fetch issues on the first clock edge after rst_b deasserts, if halt=0.

Verification
REQ-038 Reset release with halt=0 and 1-cycle memory of 32'h2008_0005 at address 0:
  - imem_addr=0, then inst_valid=1, opcode=6'b001000, inst_pc=0.
  - With inst_ready=1: fetch_count=1, next imem_addr=4.
REQ-039 inst_ready=0 for 5 cycles: inst, inst_pc and opcode stay stable and fetch_count is unchanged.
REQ-040 Redirect to 32'h0000_0103 while WAIT has a 3-cycle memory latency:
  - imem_addr is held until imem_valid, and that response is dropped.
  - The next imem_addr is 32'h0000_0100.
REQ-041 Redirect coincident with inst_ready in HOLD:
  - fetch_count is unchanged, inst_valid=0 next cycle, and the next fetch uses the target.
REQ-042 pc=32'hFFFF_FFFC fetch accepted -> next imem_addr=0.
REQ-043 rst_b pulsed low mid-WAIT:
  - imem_req=0 immediately, without waiting for a clock edge.
  - After release, the fetch is from RESET_PC and the stale imem_valid is ignored.
